// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and constants for the memory-side responder (mem_ctrl).
//   state_e        : controller FSM states
//   SZ_B/SZ_H/SZ_W : load/store size codes carried on ls_size
//   IO_HI_DEFAULT  : addr[17:16] value that selects the IO region
//   size_to_bytes  : size code -> byte count (illegal code 3 behaves as word)
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IC_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

    // Instruction fetches are always full words.
    localparam logic [2:0] FETCH_BYTES = 3'd4;

    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Serialises instruction-cache word fetches and 1/2/4-byte load/store accesses
// onto a byte-wide single-port RAM with a registered (1-cycle) read port.
// Read bytes are assembled little-endian and returned with a one-cycle pulse.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   ic_req/ic_addr  : cache miss request (held until ic_valid), word address
//   ic_valid/ic_data: one-cycle pulse with the fetched word
//   flush           : abort a pending fetch (branch redirect)
//   ls_req/ls_wr/ls_size/ls_addr/ls_wdata : load/store request (held until ls_done)
//   ls_done/ls_rdata: one-cycle pulse; load data (zero-extended) / store committed
//   ram_din         : RAM read byte (valid the cycle after ram_a was presented)
//   ram_dout/ram_a/ram_wr : RAM write byte, byte address, write enable
//   io_buffer_full  : (MEM_CTRL_IO_STALL_EN only) back-pressure for IO stores
//
// Build option
//   MEM_CTRL_IO_STALL_EN : stores to the IO region (ls_addr[17:16] == IO_HI)
//   pause while io_buffer_full is high. Without it IO stores never stall.
// -----------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = IO_HI_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [31:0]       ic_addr,
    output logic              ic_valid,
    output logic [31:0]       ic_data,
    input  logic              flush,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [31:0]       ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
`ifdef MEM_CTRL_IO_STALL_EN
    ,
    input  logic              io_buffer_full
`endif
);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_e              state_q;
    logic [2:0]          cnt_q;      // edges since accept (reads) / next byte to write
    logic [2:0]          n_q;        // transfer length in bytes
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         sh_q;       // byte assembler, bytes enter at the top

    logic                ic_valid_q;
    logic                ls_done_q;
    logic [31:0]         ic_data_q;
    logic [31:0]         ls_rdata_q;
    logic [ADDR_W-1:0]   ram_a_q;
    logic [7:0]          ram_dout_q;
    logic                ram_wr_q;

    assign ic_valid = ic_valid_q;
    assign ls_done  = ls_done_q;
    assign ic_data  = ic_data_q;
    assign ls_rdata = ls_rdata_q;
    assign ram_a    = ram_a_q;
    assign ram_dout = ram_dout_q;
    assign ram_wr   = ram_wr_q;

    // -------------------------------------------------------------------------
    // Next-value helpers
    // -------------------------------------------------------------------------
    logic        io_full_d;
    logic        wr_stall_d;
    logic [31:0] shift_in_d;
    logic [2:0]  pad_d;
    logic [31:0] rd_word_d;

`ifdef MEM_CTRL_IO_STALL_EN
    assign io_full_d = io_buffer_full;
`else
    assign io_full_d = 1'b0;
`endif

    // ls_addr is held for the whole request, so it can be tested directly.
    assign wr_stall_d = (ls_addr[17:16] == IO_HI) && io_full_d;

    // After N shifts the first byte sits at [32-8N +: 8]; shifting right by the
    // unused byte count lands byte0 at [7:0] and leaves the upper bytes zero.
    assign shift_in_d = {ram_din, sh_q[31:8]};
    assign pad_d      = 3'd4 - n_q;
    assign rd_word_d  = shift_in_d >> {pad_d, 3'b000};

    // -------------------------------------------------------------------------
    // Controller FSM
    // -------------------------------------------------------------------------
    // NOTE: every register here is written with <= so all right-hand sides see
    // the pre-edge values; a blocking = would make later lines see new values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sh_q       <= '0;
            ic_valid_q <= 1'b0;
            ls_done_q  <= 1'b0;
            ic_data_q  <= '0;
            ls_rdata_q <= '0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
        end else begin
            // Pulses last exactly one cycle.
            ic_valid_q <= 1'b0;
            ls_done_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    ram_wr_q <= 1'b0;
                    // A requester sees its pulse and drops req one cycle later,
                    // so its own pulse blocks re-acceptance of the stale req.
                    if (ls_req && !ls_done_q) begin
                        addr_q     <= ls_addr[ADDR_W-1:0];
                        n_q        <= size_to_bytes(ls_size);
                        wdata_q    <= ls_wdata;
                        sh_q       <= '0;
                        ram_a_q    <= ls_addr[ADDR_W-1:0];
                        ram_dout_q <= ls_wdata[7:0];
                        if (ls_wr) begin
                            state_q <= LS_WR;
                            if (wr_stall_d) begin
                                ram_wr_q <= 1'b0;
                                cnt_q    <= 3'd0;
                            end else begin
                                ram_wr_q <= 1'b1;
                                cnt_q    <= 3'd1;
                            end
                        end else begin
                            state_q <= LS_RD;
                            cnt_q   <= 3'd1;
                        end
                    end else if (ic_req && !ic_valid_q && !flush) begin
                        state_q <= IC_RD;
                        addr_q  <= ic_addr[ADDR_W-1:0];
                        n_q     <= FETCH_BYTES;
                        sh_q    <= '0;
                        ram_a_q <= ic_addr[ADDR_W-1:0];
                        cnt_q   <= 3'd1;
                    end
                end

                // Edge k after accept: present byte k (k < N); capture byte k-2
                // (k >= 2) because the RAM returns data one cycle after the
                // address edge; at k = N+1 the last byte is in and we finish.
                IC_RD, LS_RD: begin
                    if (state_q == IC_RD && flush) begin
                        state_q <= IDLE;
                    end else begin
                        if (cnt_q < n_q) begin
                            ram_a_q <= addr_q + ADDR_W'(cnt_q);
                        end
                        if (cnt_q >= 3'd2) begin
                            sh_q <= shift_in_d;
                        end
                        if (cnt_q == n_q + 3'd1) begin
                            state_q <= IDLE;
                            if (state_q == IC_RD) begin
                                ic_valid_q <= 1'b1;
                                ic_data_q  <= rd_word_d;
                            end else begin
                                ls_done_q  <= 1'b1;
                                ls_rdata_q <= rd_word_d;
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end

                // cnt_q is the next byte to issue. A stall re-presents that byte
                // with ram_wr low, so each byte is written exactly once.
                LS_WR: begin
                    if (cnt_q == n_q) begin
                        ram_wr_q  <= 1'b0;
                        ls_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        ram_a_q    <= addr_q + ADDR_W'(cnt_q);
                        ram_dout_q <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        if (wr_stall_d) begin
                            ram_wr_q <= 1'b0;
                        end else begin
                            ram_wr_q <= 1'b1;
                            cnt_q    <= cnt_q + 3'd1;
                        end
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    ram_wr_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Directed bench for mem_ctrl with a byte-wide registered-read RAM model.
// Latencies are counted as edges after the accepting edge E0 (lat = k means
// the pulse is visible just after edge Ek).
// -----------------------------------------------------------------------------
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_data;
    logic        flush;
    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
`ifdef MEM_CTRL_IO_STALL_EN
    logic        io_buffer_full;
`endif

    int n_asserts = 0;
    int n_fails   = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk      (clk),
        .rst      (rst),
        .ic_req   (ic_req),
        .ic_addr  (ic_addr),
        .ic_valid (ic_valid),
        .ic_data  (ic_data),
        .flush    (flush),
        .ls_req   (ls_req),
        .ls_wr    (ls_wr),
        .ls_size  (ls_size),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_done  (ls_done),
        .ls_rdata (ls_rdata),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .ram_a    (ram_a),
        .ram_wr   (ram_wr)
`ifdef MEM_CTRL_IO_STALL_EN
        ,
        .io_buffer_full (io_buffer_full)
`endif
    );

    // RAM model: 256 KiB aliased window, registered read, write-log queues.
    logic [7:0]  mem [0:262143];
    logic [31:0] wr_a_log [$];
    logic [7:0]  wr_d_log [$];

    always @(posedge clk) begin
        ram_din <= mem[ram_a[17:0]];
        if (ram_wr) begin
            mem[ram_a[17:0]] <= ram_dout;
            wr_a_log.push_back(ram_a);
            wr_d_log.push_back(ram_dout);
        end
    end

    int ic_pulses = 0;
    int ls_pulses = 0;
    always @(posedge clk) begin
        if (ic_valid) ic_pulses++;
        if (ls_done)  ls_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Wait for the ic_valid (is_ls = 0) or ls_done (is_ls = 1) pulse; lat = -1
    // when the budget expires, which fails the caller's latency comparison.
    task automatic wait_pulse(input bit is_ls, input int budget, output int lat);
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if ((is_ls ? ls_done : ic_valid) === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int          lat;
    int          ls_lat;
    int          ic_lat;
    int          pre;
    int          wr_hi;
    int          first_wr;
    logic [31:0] exp_word;

    initial begin
        rst      = 1'b1;
        ic_req   = 1'b0;
        ic_addr  = '0;
        flush    = 1'b0;
        ls_req   = 1'b0;
        ls_wr    = 1'b0;
        ls_size  = SZ_B;
        ls_addr  = '0;
        ls_wdata = '0;
`ifdef MEM_CTRL_IO_STALL_EN
        io_buffer_full = 1'b0;
`endif
        for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
        mem[18'h00100] = 8'h13; mem[18'h00101] = 8'h05;
        mem[18'h00102] = 8'h10; mem[18'h00103] = 8'h00;
        mem[18'h00104] = 8'h93; mem[18'h00105] = 8'h05;
        mem[18'h00106] = 8'h20; mem[18'h00107] = 8'h00;
        mem[18'h00202] = 8'hEF; mem[18'h00203] = 8'hBE;
        mem[18'h00050] = 8'hA5;
        mem[18'h3FFFF] = 8'h11; mem[18'h00000] = 8'h22;
        mem[18'h00402] = 8'h77;

        // ---- reset state
        idle(3);
        check("rst_ic_valid", 32'(ic_valid), 32'd0);
        check("rst_ls_done",  32'(ls_done),  32'd0);
        check("rst_ram_wr",   32'(ram_wr),   32'd0);
        check("rst_ram_a",    ram_a,         32'd0);
        check("rst_ram_dout", 32'(ram_dout), 32'd0);
        check("rst_ic_data",  ic_data,       32'd0);
        check("rst_ls_rdata", ls_rdata,      32'd0);
        rst = 1'b0;
        idle(1);

        // ---- word fetch at 0x100: pulse after E5, one pulse only
        ic_addr = 32'h100; ic_req = 1'b1;
        wait_pulse(1'b0, 20, lat);
        ic_req = 1'b0;
        check("fetch_lat",  lat,     32'd5);
        check("fetch_data", ic_data, 32'h00100513);
        idle(3);
        check("fetch_pulses", ic_pulses, 32'd1);

        // ---- load half at 0x202
        ls_addr = 32'h202; ls_size = SZ_H; ls_wr = 1'b0; ls_req = 1'b1;
        wait_pulse(1'b1, 20, lat);
        ls_req = 1'b0;
        check("ldh_lat",   lat,      32'd3);
        check("ldh_rdata", ls_rdata, 32'h0000BEEF);
        idle(2);

        // ---- store word 0xDEADBEEF at 0x300
        wr_a_log.delete(); wr_d_log.delete();
        ls_addr = 32'h300; ls_size = SZ_W; ls_wr = 1'b1; ls_wdata = 32'hDEADBEEF; ls_req = 1'b1;
        wait_pulse(1'b1, 20, lat);
        ls_req = 1'b0; ls_wr = 1'b0;
        check("stw_lat", lat, 32'd4);
        idle(2);
        check("stw_nwrites", wr_a_log.size(), 32'd4);
        exp_word = 32'hDEADBEEF;
        for (int i = 0; i < 4 && i < wr_a_log.size(); i++) begin
            check($sformatf("stw_addr%0d", i), wr_a_log[i], 32'h300 + 32'(i));
            check($sformatf("stw_data%0d", i), 32'(wr_d_log[i]), 32'(exp_word[8*i +: 8]));
        end
        ls_addr = 32'h300; ls_size = SZ_W; ls_req = 1'b1;
        wait_pulse(1'b1, 20, lat);
        ls_req = 1'b0;
        check("ldw_lat",   lat,      32'd5);
        check("ldw_rdata", ls_rdata, 32'hDEADBEEF);
        check("ic_data_hold", ic_data, 32'h00100513);
        idle(2);

        // ---- simultaneous requests: load byte first, then the fetch
        ls_addr = 32'h50; ls_size = SZ_B; ls_wr = 1'b0; ls_req = 1'b1;
        ic_addr = 32'h104; ic_req = 1'b1;
        ls_lat = -1; ic_lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ls_done === 1'b1) begin
                ls_lat = k;
                ls_req = 1'b0;
                check("both_ls_rdata", ls_rdata, 32'h000000A5);
            end
            if (ic_valid === 1'b1) begin
                ic_lat = k;
                ic_req = 1'b0;
                break;
            end
        end
        ls_req = 1'b0; ic_req = 1'b0;
        check("both_ls_lat",  ls_lat,  32'd2);
        check("both_ic_lat",  ic_lat,  32'd8);
        check("both_ic_data", ic_data, 32'h00200593);
        idle(3);

        // ---- flush two cycles into a fetch
        pre = ic_pulses;
        ic_addr = 32'h100; ic_req = 1'b1;
        idle(1);                          // E0
        idle(1);                          // E1
        flush = 1'b1; ic_req = 1'b0;
        idle(1);                          // E2: back to IDLE
        flush = 1'b0;
        check("flush_ram_a_e2", ram_a, 32'h101);
        idle(8);
        check("flush_ram_a_hold", ram_a,     32'h101);
        check("flush_no_pulse",   ic_pulses, pre);
        ic_addr = 32'h104; ic_req = 1'b1;
        wait_pulse(1'b0, 20, lat);
        ic_req = 1'b0;
        check("post_flush_lat",  lat,     32'd5);
        check("post_flush_data", ic_data, 32'h00200593);
        idle(2);

        // ---- flush in IDLE blocks acceptance for that edge only
        ic_addr = 32'h100; ic_req = 1'b1; flush = 1'b1;
        idle(1);
        flush = 1'b0;
        wait_pulse(1'b0, 20, lat);
        ic_req = 1'b0;
        check("flush_idle_lat",  lat,     32'd5);
        check("flush_idle_data", ic_data, 32'h00100513);
        idle(2);

        // ---- address wrap: half load at 0xFFFFFFFF reads bytes at -1 and 0
        ls_addr = 32'hFFFF_FFFF; ls_size = SZ_H; ls_wr = 1'b0; ls_req = 1'b1;
        wait_pulse(1'b1, 20, lat);
        ls_req = 1'b0;
        check("wrap_lat",   lat,      32'd3);
        check("wrap_rdata", ls_rdata, 32'h00002211);
        idle(2);

        // ---- IO store byte at 0x30000 (stalled 3 cycles when the option is on)
        wr_a_log.delete(); wr_d_log.delete();
        ls_addr = 32'h30000; ls_size = SZ_B; ls_wr = 1'b1; ls_wdata = 32'h0000005A; ls_req = 1'b1;
`ifdef MEM_CTRL_IO_STALL_EN
        io_buffer_full = 1'b1;
`endif
        lat = -1; wr_hi = 0; first_wr = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (ram_wr === 1'b1) begin
                wr_hi++;
                if (first_wr < 0) first_wr = k;
            end
`ifdef MEM_CTRL_IO_STALL_EN
            if (k == 2) io_buffer_full = 1'b0;
`endif
            if (ls_done === 1'b1) begin
                lat = k;
                break;
            end
        end
        ls_req = 1'b0; ls_wr = 1'b0;
        idle(2);
`ifdef MEM_CTRL_IO_STALL_EN
        check("io_lat",      lat,      32'd4);
        check("io_first_wr", first_wr, 32'd3);
`else
        check("io_lat",      lat,      32'd1);
        check("io_first_wr", first_wr, 32'd0);
`endif
        check("io_wr_cycles", wr_hi,           32'd1);
        check("io_nwrites",   wr_a_log.size(), 32'd1);
        if (wr_a_log.size() > 0) begin
            check("io_addr", wr_a_log[0],       32'h30000);
            check("io_data", 32'(wr_d_log[0]),  32'h5A);
        end

        // ---- reset in the middle of a word store
        pre = ls_pulses;
        ls_addr = 32'h400; ls_size = SZ_W; ls_wr = 1'b1; ls_wdata = 32'h44332211; ls_req = 1'b1;
        idle(1);                          // E0: byte0 presented
        idle(1);                          // E1: byte0 written, byte1 presented
        rst = 1'b1; ls_req = 1'b0; ls_wr = 1'b0;
        idle(1);                          // E2: byte1 written, controller reset
        check("midrst_ram_wr", 32'(ram_wr), 32'd0);
        check("midrst_ram_a",  ram_a,       32'd0);
        rst = 1'b0;
        idle(3);
        check("midrst_b0",     32'(mem[18'h00400]), 32'h11);
        check("midrst_b1",     32'(mem[18'h00401]), 32'h22);
        check("midrst_b2",     32'(mem[18'h00402]), 32'h77);
        check("midrst_nodone", ls_pulses,           pre);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
